// File: rtl/exp_logic_pipe.sv
// Exponent datapath for the FP MAC: product exponent, Eab-Ec difference, max exponent and
// clamped C-alignment shift, behind a STAGES-deep valid/ready pipeline with bubble collapse.
module exp_logic_pipe #(
  parameter int SIG_WIDTH = 23,
  parameter int EX_WIDTH  = 8,
  parameter int STAGES    = 2,
  parameter int SHIFT_MAX = 3*SIG_WIDTH+5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EX_WIDTH-1:0]   Ea,
  input  logic [EX_WIDTH-1:0]   Eb,
  input  logic [EX_WIDTH-1:0]   Ec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EX_WIDTH+1:0]   shift,
  output logic [EX_WIDTH+1:0]   sd,
  output logic [EX_WIDTH+1:0]   max_exp,
  output logic                  prod_undf,
  output logic                  prod_ovf,
  output logic                  shift_sat
);
  localparam int W  = EX_WIDTH + 2;
  localparam logic [W-1:0] BIAS = W'((1 << (EX_WIDTH-1)) - 1);
  localparam logic [W-1:0] EMAX = W'((1 << EX_WIDTH) - 2);
  localparam logic [W-1:0] SMAX = W'(SHIFT_MAX);
  localparam logic [W-1:0] SOFF = W'(SIG_WIDTH + 4);
  // Result registers occupy the last RS stages; with STAGES>=2 stage 1 only holds Eab/Ec.
  localparam int RS = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int R0 = STAGES - RS + 1;

  typedef struct packed {
    logic [W-1:0] shift;
    logic [W-1:0] sd;
    logic [W-1:0] max_exp;
    logic         undf;
    logic         ovf;
    logic         sat;
  } res_t;

  function automatic res_t calc(input logic [W-1:0] eab, input logic [EX_WIDTH-1:0] ec);
    res_t         r;
    logic [W-1:0] d;
    logic [W-1:0] ss;
    logic         hi;
    d         = eab - {2'b00, ec};
    ss        = d + SOFF;
    hi        = $signed(ss) > $signed(SMAX);
    r.sd      = d;
    r.max_exp = d[W-1] ? {2'b00, ec} : eab;
    r.undf    = eab[W-1];
    r.ovf     = $signed(eab) > $signed(EMAX);
    r.sat     = ss[W-1] | hi;
    r.shift   = ss[W-1] ? '0 : (hi ? SMAX : ss);
    return r;
  endfunction

  logic [W-1:0]      eab_in;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES+1:1] rdy;
  logic [STAGES:1]   ld;
  res_t              res_d0;
  res_t              res_q [RS];

  assign eab_in   = {2'b00, Ea} + {2'b00, Eb} - BIAS;
  assign vld_pipe = {vld_q, in_valid};
  assign rdy[STAGES+1] = out_ready;

  genvar k;
  generate
    for (k = 1; k <= STAGES; k++) begin : g_rdy
      assign rdy[k] = !vld_q[k] || rdy[k+1];
    end
  endgenerate

  assign ld = rdy[STAGES:1] & vld_pipe[STAGES-1:0];

  // A stage holds while blocked downstream and otherwise takes whatever sits upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_q <= '0;
    else if (flush) vld_q <= '0;
    else            vld_q <= (vld_q & ~rdy[STAGES:1]) | (vld_pipe[STAGES-1:0] & rdy[STAGES:1]);
  end

  generate
    if (STAGES > 1) begin : g_s1
      logic [W-1:0]        eab_q;
      logic [EX_WIDTH-1:0] ec_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          eab_q <= '0;
          ec_q  <= '0;
        end else if (ld[1]) begin
          eab_q <= eab_in;
          ec_q  <= Ec;
        end
      end
      assign res_d0 = calc(eab_q, ec_q);
    end else begin : g_s0
      assign res_d0 = calc(eab_in, Ec);
    end

    for (k = 0; k < RS; k++) begin : g_res
      if (k == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)        res_q[k] <= '0;
          else if (ld[R0+k]) res_q[k] <= res_d0;
        end
      end else begin : g_delay
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)        res_q[k] <= '0;
          else if (ld[R0+k]) res_q[k] <= res_q[k-1];
        end
      end
    end
  endgenerate

  assign in_ready  = rdy[1];
  assign out_valid = vld_q[STAGES];
  assign shift     = res_q[RS-1].shift;
  assign sd        = res_q[RS-1].sd;
  assign max_exp   = res_q[RS-1].max_exp;
  assign prod_undf = res_q[RS-1].undf;
  assign prod_ovf  = res_q[RS-1].ovf;
  assign shift_sat = res_q[RS-1].sat;
endmodule

// File: tb/tb_exp_logic_pipe.sv
// Scoreboard bench: STAGES=2 DUT under stall/flush/reset, plus STAGES=1 and STAGES=4 copies
// fed the same accepted transactions with out_ready tied high.
module tb_exp_logic_pipe;
  localparam int W  = 10;
  localparam int NB = 3*W + 3;

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [7:0] Ea = 0, Eb = 0, Ec = 0;
  logic in_ready, out_valid, prod_undf, prod_ovf, shift_sat;
  logic [W-1:0] shift, sd, max_exp;
  logic b_in_valid;
  logic a_in_ready, a_out_valid, a_undf, a_ovf, a_sat;
  logic [W-1:0] a_shift, a_sd, a_max;
  logic c_in_ready, c_out_valid, c_undf, c_ovf, c_sat;
  logic [W-1:0] c_shift, c_sd, c_max;
  logic one = 1'b1;

  assign b_in_valid = in_valid & in_ready;

  exp_logic_pipe #(.STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Ea(Ea), .Eb(Eb), .Ec(Ec), .out_valid(out_valid), .out_ready(out_ready),
    .shift(shift), .sd(sd), .max_exp(max_exp),
    .prod_undf(prod_undf), .prod_ovf(prod_ovf), .shift_sat(shift_sat));

  exp_logic_pipe #(.STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_ready(a_in_ready),
    .Ea(Ea), .Eb(Eb), .Ec(Ec), .out_valid(a_out_valid), .out_ready(one),
    .shift(a_shift), .sd(a_sd), .max_exp(a_max),
    .prod_undf(a_undf), .prod_ovf(a_ovf), .shift_sat(a_sat));

  exp_logic_pipe #(.STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(b_in_valid), .in_ready(c_in_ready),
    .Ea(Ea), .Eb(Eb), .Ec(Ec), .out_valid(c_out_valid), .out_ready(one),
    .shift(c_shift), .sd(c_sd), .max_exp(c_max),
    .prod_undf(c_undf), .prod_ovf(c_ovf), .shift_sat(c_sat));

  always #5 clk = ~clk;

  logic [NB-1:0] q2[$], q1[$], q4[$];
  int checks = 0, errors = 0, occ = 0, cyc = 0, stall_lo = -1, stall_hi = -1;
  bit rmode = 0;

  task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  task automatic spurious(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got out_valid=1 expected no pending result", nm);
  endtask

  function automatic logic [NB-1:0] model(input int a, input int b, input int c);
    int eab, d, ss, sh, mx;
    eab = a + b - 127;
    d   = eab - c;
    ss  = d + 27;
    sh  = (ss < 0) ? 0 : ((ss > 74) ? 74 : ss);
    mx  = (d < 0) ? c : eab;
    return {10'(sh), 10'(d), 10'(mx), 1'(eab < 0), 1'(eab > 254), 1'((ss < 0) || (ss > 74))};
  endfunction

  // Monitor: in_ready model from occupancy, and in-order compare of every presented result.
  always @(negedge clk) begin
    if (!rst_n) occ = 0;
    else begin
      chk("in_ready", NB'(in_ready), NB'(!(occ == 2 && !out_ready)));
      chk("in_ready_s1s4", NB'({a_in_ready, c_in_ready}), NB'(2'b11));
      if (out_valid) begin
        if (q2.size() == 0) spurious("out_s2");
        else begin
          chk("out_s2", {shift, sd, max_exp, prod_undf, prod_ovf, shift_sat}, q2[0]);
          if (out_ready) void'(q2.pop_front());
        end
      end
      if (a_out_valid) begin
        if (q1.size() == 0) spurious("out_s1");
        else chk("out_s1", {a_shift, a_sd, a_max, a_undf, a_ovf, a_sat}, q1.pop_front());
      end
      if (c_out_valid) begin
        if (q4.size() == 0) spurious("out_s4");
        else chk("out_s4", {c_shift, c_sd, c_max, c_undf, c_ovf, c_sat}, q4.pop_front());
      end
      occ = flush ? 0 : occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    out_ready = rmode ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) tick();
  endtask

  task automatic send(input int a, input int b, input int c, input logic [NB-1:0] e);
    int n = 0;
    bit acc = 0;
    Ea = 8'(a); Eb = 8'(b); Ec = 8'(c);
    in_valid = 1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        q2.push_back(e); q1.push_back(e); q4.push_back(e);
      end
      tick();
      n++;
    end
    in_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic clear_q();
    q2.delete(); q1.delete(); q4.delete();
  endtask

  int va[10], vb[10], vc[10];
  logic [NB-1:0] ve[10];

  initial begin
    va[0]=127; vb[0]=127; vc[0]=127; ve[0]={10'd27, 10'd0,    10'd127, 3'b000};
    va[1]=1;   vb[1]=1;   vc[1]=0;   ve[1]={10'd0,  10'h383,  10'd0,   3'b101};
    va[2]=254; vb[2]=254; vc[2]=0;   ve[2]={10'd74, 10'd381,  10'd381, 3'b011};
    va[3]=130; vb[3]=120; vc[3]=140; ve[3]={10'd10, 10'h3EF,  10'd140, 3'b000};
    va[4]=200; vb[4]=100; vc[4]=50;  ve[4]={10'd74, 10'd123,  10'd173, 3'b001};
    va[5]=128; vb[5]=127; vc[5]=200; ve[5]={10'd0,  10'h3B8,  10'd200, 3'b001};
    va[6]=127; vb[6]=100; vc[6]=53;  ve[6]={10'd74, 10'd47,   10'd100, 3'b000};
    va[7]=127; vb[7]=100; vc[7]=127; ve[7]={10'd0,  10'h3E5,  10'd127, 3'b000};
    va[8]=254; vb[8]=127; vc[8]=254; ve[8]={10'd27, 10'd0,    10'd254, 3'b000};
    va[9]=255; vb[9]=127; vc[9]=255; ve[9]={10'd27, 10'd0,    10'd255, 3'b010};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", NB'({out_valid, in_ready}), NB'(2'b01));
    chk("reset_data", {shift, sd, max_exp, prod_undf, prod_ovf, shift_sat}, '0);
    rst_n = 1;
    tick();

    // Directed stream with out_ready low on cycles 3..5
    cyc = 0; stall_lo = 3; stall_hi = 5;
    for (int i = 0; i < 10; i++) send(va[i], vb[i], vc[i], ve[i]);
    idle(8);

    // Flush with the STAGES=2 pipe full; the same-cycle input is dropped
    stall_lo = 0; stall_hi = 1000000; cyc = 0; out_ready = 0;
    send(va[2], vb[2], vc[2], ve[2]);
    send(va[3], vb[3], vc[3], ve[3]);
    flush = 1; in_valid = 1; Ea = 8'd10; Eb = 8'd20; Ec = 8'd30;
    @(posedge clk);
    #1;
    flush = 0; in_valid = 0;
    clear_q();
    chk("flush_ctl", NB'({out_valid, in_ready}), NB'(2'b01));
    stall_lo = -1; stall_hi = -1;
    idle(6);

    // Asynchronous reset with the pipe full
    stall_lo = 0; stall_hi = 1000000; cyc = 0; out_ready = 0;
    send(va[4], vb[4], vc[4], ve[4]);
    send(va[5], vb[5], vc[5], ve[5]);
    rst_n = 0;
    #1;
    chk("arst_ctl", NB'({out_valid, in_ready}), NB'(2'b01));
    chk("arst_data", {shift, sd, max_exp, prod_undf, prod_ovf, shift_sat}, '0);
    clear_q();
    tick(); tick();
    rst_n = 1;
    stall_lo = -1; stall_hi = -1;
    idle(4);

    // Latency after reset
    begin
      int lat = 1;
      send(va[0], vb[0], vc[0], ve[0]);
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk("latency", NB'(lat), NB'(2));
    end
    idle(4);

    // Random sweep with random out_ready
    rmode = 1;
    repeat (80) begin
      int a, b, c;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) idle(1);
      send(a, b, c, model(a, b, c));
    end
    rmode = 0;
    idle(12);

    chk("drain_s2", NB'(q2.size()), '0);
    chk("drain_s1", NB'(q1.size()), '0);
    chk("drain_s4", NB'(q4.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1);
  end
endmodule
